// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI slave command parser and register file in the sysclk domain
module spi_reg_ctrl #(
  parameter int         NREGS  = 8,
  parameter logic [7:0] DEV_ID = 8'hF0
) (
  input  logic               sysclk,
  input  logic               rstn,
  input  logic               iRxReady,
  input  logic [7:0]         iRx,
  input  logic               iSPICS,
  output logic [7:0]         oTx,
  output logic               oTxReady,
  output logic [8*NREGS-1:0] oRegs,
  output logic               oWrStb,
  output logic [3:0]         oWrAddr,
  output logic               oErr
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  localparam logic [4:0] NREGS_L = 5'(NREGS);

  logic       rx_s1_q, rx_s2_q, rx_s3_q, evt_q;
  logic       cs_s1_q, cs_s2_q, cs_s3_q, cs_s4_q;
  logic [7:0] rx_q;
  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d, wraddr_q, wraddr_d;
  logic [7:0] tx_q, tx_d;
  logic       txrdy_q, txrdy_d, wrstb_q, wrstb_d, err_q, err_d;
  logic       wpend_q, wpend_d, we;
  logic [7:0] regs_q [16];

  logic       cs_fall, cs_hi;
  logic [3:0] addr_inc;
  logic [7:0] rd_cmd, rd_next;

  // cs_s3_q is aligned with evt_q so a byte and a CS rise in the same cycle are seen together
  assign cs_fall  = cs_s4_q & ~cs_s3_q;
  assign cs_hi    = cs_s3_q;
  assign addr_inc = addr_q + 4'd1;
  assign rd_cmd   = ({1'b0, rx_q[3:0]} < NREGS_L) ? regs_q[rx_q[3:0]] : 8'h00;
  assign rd_next  = ({1'b0, addr_inc} < NREGS_L) ? regs_q[addr_inc] : 8'h00;

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      rx_s1_q  <= 1'b0;
      rx_s2_q  <= 1'b0;
      rx_s3_q  <= 1'b0;
      evt_q    <= 1'b0;
      cs_s1_q  <= 1'b0;
      cs_s2_q  <= 1'b0;
      cs_s3_q  <= 1'b0;
      cs_s4_q  <= 1'b0;
      rx_q     <= 8'h00;
      state_q  <= IDLE;
      addr_q   <= 4'd0;
      tx_q     <= 8'h00;
      txrdy_q  <= 1'b0;
      wrstb_q  <= 1'b0;
      wraddr_q <= 4'd0;
      err_q    <= 1'b0;
      wpend_q  <= 1'b0;
      for (int k = 0; k < 16; k++) regs_q[k] <= 8'h00;
    end else begin
      rx_s1_q  <= iRxReady;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      evt_q    <= rx_s2_q & ~rx_s3_q;
      cs_s1_q  <= iSPICS;
      cs_s2_q  <= cs_s1_q;
      cs_s3_q  <= cs_s2_q;
      cs_s4_q  <= cs_s3_q;
      if (rx_s2_q & ~rx_s3_q) rx_q <= iRx;
      state_q  <= state_d;
      addr_q   <= addr_d;
      tx_q     <= tx_d;
      txrdy_q  <= txrdy_d;
      wrstb_q  <= wrstb_d;
      wraddr_q <= wraddr_d;
      err_q    <= err_d;
      wpend_q  <= wpend_d;
      if (we) regs_q[addr_q] <= rx_q;
    end
  end

  // A write command closed by CS before any data byte counts as an empty frame too
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tx_d     = tx_q;
    txrdy_d  = 1'b0;
    wrstb_d  = 1'b0;
    wraddr_d = wraddr_q;
    err_d    = 1'b0;
    wpend_d  = wpend_q;
    we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          tx_d    = DEV_ID;
          txrdy_d = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        if (evt_q) begin
          addr_d  = rx_q[3:0];
          txrdy_d = 1'b1;
          if (rx_q[7]) begin
            tx_d    = rx_q;
            wpend_d = 1'b1;
            state_d = WDATA;
          end else begin
            tx_d    = rd_cmd;
            state_d = RDATA;
          end
        end else if (cs_hi) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WDATA: begin
        if (evt_q) begin
          tx_d    = rx_q;
          txrdy_d = 1'b1;
          addr_d  = addr_inc;
          wpend_d = 1'b0;
          if ({1'b0, addr_q} < NREGS_L) begin
            we       = 1'b1;
            wrstb_d  = 1'b1;
            wraddr_d = addr_q;
          end else begin
            err_d = 1'b1;
          end
        end else if (cs_hi) begin
          err_d   = wpend_q;
          state_d = IDLE;
        end
      end
      RDATA: begin
        if (evt_q) begin
          addr_d  = addr_inc;
          tx_d    = rd_next;
          txrdy_d = 1'b1;
        end else if (cs_hi) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_regs
    assign oRegs[8*k +: 8] = regs_q[k];
  end

  assign oTx      = tx_q;
  assign oTxReady = txrdy_q;
  assign oWrStb   = wrstb_q;
  assign oWrAddr  = wraddr_q;
  assign oErr     = err_q;

endmodule
